// File: rtl/zjh_cs_arbiter.sv
// Round-robin chip-select arbiter driving the E/A inputs of a 3-to-8 active-low decoder.
// One grant at a time, each bounded by HOLD_MAX cycles and followed by a GAP_CYC guard gap.
module zjh_cs_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int GAP_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [2:0] E,
  output logic [2:0] A,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  localparam logic [2:0] E_ON  = 3'b100;
  localparam logic [2:0] E_OFF = 3'b011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] last, last_nxt;
  logic [2:0] e_nxt, a_nxt;
  logic [7:0] grant_nxt;
  logic       busy_nxt, timeout_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic [7:0] gap_cnt, gap_nxt;
  logic [2:0] pick, cand;
  logic       hold_limit;

  assign hold_limit = (hold_cnt == 8'(HOLD_MAX - 1));

  // Scan downward from last+8 to last+1 so the nearest requester after last wins.
  always_comb begin
    pick = last;
    cand = last;
    for (int k = 8; k >= 1; k--) begin
      cand = last + 3'(k);
      if (req[cand]) pick = cand;
    end
  end

  always_comb begin
    state_nxt   = state;
    e_nxt       = E;
    a_nxt       = A;
    grant_nxt   = grant;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    last_nxt    = last;
    hold_nxt    = hold_cnt;
    gap_nxt     = gap_cnt;
    case (state)
      IDLE: begin
        if (en && (req != 8'd0)) begin
          state_nxt = ACTIVE;
          e_nxt     = E_ON;
          a_nxt     = pick;
          grant_nxt = 8'd1 << pick;
          busy_nxt  = 1'b1;
          last_nxt  = pick;
          hold_nxt  = 8'd0;
        end
      end
      ACTIVE: begin
        if (!req[A] || !en || hold_limit) begin
          state_nxt   = GAP;
          e_nxt       = E_OFF;
          grant_nxt   = 8'd0;
          gap_nxt     = 8'd0;
          // A release or disable on the limit cycle is not a timeout.
          timeout_nxt = hold_limit && req[A] && en;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt == 8'(GAP_CYC - 1)) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          gap_nxt = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      E        <= E_OFF;
      A        <= 3'd0;
      grant    <= 8'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      last     <= 3'd7;
      hold_cnt <= 8'd0;
      gap_cnt  <= 8'd0;
    end else begin
      state    <= state_nxt;
      E        <= e_nxt;
      A        <= a_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_zjh_cs_arbiter.sv
// Bench for zjh_cs_arbiter: two instances (HOLD_MAX 16 and 4) share stimulus; directed
// vectors, hand sequences and random traffic are scored against a behavioural model.
module tb_zjh_cs_arbiter;

  localparam int GAP = 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;

  logic [2:0] a_e, a_a, b_e, b_a;
  logic [7:0] a_grant, b_grant;
  logic       a_busy, a_to, b_busy, b_to;

  int errors;
  int checks;

  logic [15:0] exp_q[$];

  zjh_cs_arbiter #(.HOLD_MAX(16), .GAP_CYC(GAP)) u_a (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .E(a_e), .A(a_a), .grant(a_grant), .busy(a_busy), .timeout(a_to)
  );

  zjh_cs_arbiter #(.HOLD_MAX(4), .GAP_CYC(GAP)) u_b (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .E(b_e), .A(b_a), .grant(b_grant), .busy(b_busy), .timeout(b_to)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural model: owner, enabled-cycle age, remaining gap cycles
  int m_on[2], m_age[2], m_gap[2], m_last[2], m_a[2], m_to[2];

  task automatic model_step(input int m, input int hold_max);
    int idx;
    logic [15:0] exp_v;
    if (rst) begin
      m_on[m] = 0; m_age[m] = 0; m_gap[m] = 0; m_last[m] = 7; m_a[m] = 0; m_to[m] = 0;
    end else begin
      m_to[m] = 0;
      if (m_on[m] != 0) begin
        if (!req[m_a[m]] || !en || m_age[m] == hold_max) begin
          m_to[m] = (m_age[m] == hold_max && req[m_a[m]] && en) ? 1 : 0;
          m_on[m] = 0;
          m_gap[m] = GAP;
        end else begin
          m_age[m] = m_age[m] + 1;
        end
      end else if (m_gap[m] > 0) begin
        m_gap[m] = m_gap[m] - 1;
      end else if (en && req != 8'd0) begin
        idx = -1;
        for (int d = 1; d <= 8; d++)
          if (idx < 0 && req[(m_last[m] + d) % 8]) idx = (m_last[m] + d) % 8;
        m_on[m] = 1; m_age[m] = 1; m_a[m] = idx; m_last[m] = idx;
      end
    end
    exp_v = {(m_on[m] != 0) ? 3'b100 : 3'b011, 3'(m_a[m]),
             (m_on[m] != 0) ? 8'(1 << m_a[m]) : 8'h00,
             (m_on[m] != 0 || m_gap[m] > 0), (m_to[m] != 0)};
    exp_q.push_back(exp_v);
  endtask

  always @(posedge clk) begin
    model_step(0, 16);
    model_step(1, 4);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [15:0] ea, eb;
    if (exp_q.size() >= 2) begin
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      chk("sb_hold16", {a_e, a_a, a_grant, a_busy, a_to}, ea);
      chk("sb_hold4",  {b_e, b_a, b_grant, b_busy, b_to}, eb);
    end
  end

  // driver
  task automatic tick(input logic r, input logic e, input logic [7:0] q);
    rst = r;
    en  = e;
    req = q;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] q;
    logic [2:0] xe;
    logic [2:0] xa;
    logic [7:0] xg;
    logic       xb;
    logic       xt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [7:0] q,
                     input logic [2:0] xe, input logic [2:0] xa, input logic [7:0] xg,
                     input logic xb, input logic xt);
    vec_t v;
    v.r = r; v.e = e; v.q = q; v.xe = xe; v.xa = xa; v.xg = xg; v.xb = xb; v.xt = xt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] q_prev;
    logic       r_v, e_v;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    en  = 1'b0;
    req = 8'h00;

    // single request held 5 cycles, then drop (HOLD_MAX 16 instance)
    add(1, 0, 8'h00, 3'b011, 3'd0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 8'h04, 3'b100, 3'd2, 8'h04, 1, 0);
    add(0, 1, 8'h00, 3'b011, 3'd2, 8'h00, 1, 0);
    add(0, 1, 8'h00, 3'b011, 3'd2, 8'h00, 1, 0);
    add(0, 1, 8'h00, 3'b011, 3'd2, 8'h00, 0, 0);
    // rotation wrap: last=6, req 0x41 -> 0, then 6
    add(0, 1, 8'h40, 3'b100, 3'd6, 8'h40, 1, 0);
    add(0, 1, 8'h00, 3'b011, 3'd6, 8'h00, 1, 0);
    add(0, 1, 8'h41, 3'b011, 3'd6, 8'h00, 1, 0);
    add(0, 1, 8'h41, 3'b011, 3'd6, 8'h00, 0, 0);
    add(0, 1, 8'h41, 3'b100, 3'd0, 8'h01, 1, 0);
    add(0, 1, 8'h40, 3'b011, 3'd0, 8'h00, 1, 0);
    add(0, 1, 8'h40, 3'b011, 3'd0, 8'h00, 1, 0);
    add(0, 1, 8'h40, 3'b011, 3'd0, 8'h00, 0, 0);
    add(0, 1, 8'h40, 3'b100, 3'd6, 8'h40, 1, 0);
    // en dropped mid-grant on requester 3
    add(0, 1, 8'h00, 3'b011, 3'd6, 8'h00, 1, 0);
    add(0, 1, 8'h08, 3'b011, 3'd6, 8'h00, 1, 0);
    add(0, 1, 8'h08, 3'b011, 3'd6, 8'h00, 0, 0);
    add(0, 1, 8'h08, 3'b100, 3'd3, 8'h08, 1, 0);
    add(0, 1, 8'h08, 3'b100, 3'd3, 8'h08, 1, 0);
    add(0, 0, 8'h08, 3'b011, 3'd3, 8'h00, 1, 0);
    add(0, 0, 8'h08, 3'b011, 3'd3, 8'h00, 1, 0);
    add(0, 0, 8'h08, 3'b011, 3'd3, 8'h00, 0, 0);
    add(0, 0, 8'h08, 3'b011, 3'd3, 8'h00, 0, 0);
    add(0, 0, 8'hFF, 3'b011, 3'd3, 8'h00, 0, 0);
    // reset on the second active cycle of grant 5
    add(0, 1, 8'h20, 3'b100, 3'd5, 8'h20, 1, 0);
    add(0, 1, 8'h20, 3'b100, 3'd5, 8'h20, 1, 0);
    add(1, 1, 8'h20, 3'b011, 3'd0, 8'h00, 0, 0);
    add(0, 1, 8'h20, 3'b100, 3'd5, 8'h20, 1, 0);
    add(0, 1, 8'h00, 3'b011, 3'd5, 8'h00, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].r, vecs[i].e, vecs[i].q);
      chk($sformatf("vec%0d", i), {a_e, a_a, a_grant, a_busy, a_to},
          {vecs[i].xe, vecs[i].xa, vecs[i].xg, vecs[i].xb, vecs[i].xt});
    end

    // all eight requesting, HOLD_MAX 4: rotation 0..7,0 with timeouts
    tick(1, 0, 8'h00);
    tick(0, 1, 8'hFF);
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("rr_on_g%0d_c%0d", k, c), {5'd0, b_e, b_grant, b_to},
            {5'd0, 3'b100, 8'(1 << (k % 8)), 1'b0});
        tick(0, 1, 8'hFF);
      end
      chk($sformatf("rr_timeout_g%0d", k), {11'd0, b_e, b_busy, b_to}, {11'd0, 3'b011, 1'b1, 1'b1});
      tick(0, 1, 8'hFF);
      chk($sformatf("rr_gap_g%0d", k), {11'd0, b_e, b_busy, b_to}, {11'd0, 3'b011, 1'b1, 1'b0});
      tick(0, 1, 8'hFF);
      chk($sformatf("rr_idle_g%0d", k), {11'd0, b_e, b_busy, b_to}, {11'd0, 3'b011, 1'b0, 1'b0});
      tick(0, 1, 8'hFF);
    end

    // release on the limit cycle is a normal release (HOLD_MAX 4)
    tick(1, 0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      tick(0, 1, 8'h02);
      chk($sformatf("lim_on_c%0d", c), {5'd0, b_e, b_a, b_grant}, {5'd0, 3'b100, 3'd1, 8'h02});
    end
    tick(0, 1, 8'h00);
    chk("lim_release", {11'd0, b_e, b_busy, b_to}, {11'd0, 3'b011, 1'b1, 1'b0});
    tick(0, 1, 8'h00);
    chk("lim_gap2", {11'd0, b_e, b_busy, b_to}, {11'd0, 3'b011, 1'b1, 1'b0});
    tick(0, 1, 8'h00);
    chk("lim_idle", {11'd0, b_e, b_busy, b_to}, {11'd0, 3'b011, 1'b0, 1'b0});

    // random traffic, scored every cycle against the model
    q_prev = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      r_v = ($urandom_range(0, 199) == 0);
      e_v = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) q_prev = 8'($urandom);
      tick(r_v, e_v, q_prev);
    end

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
